// File: rtl/seg7_pkg.sv
// Shared character codes, segment patterns and the character type for the
// seven-segment scan driver.
package seg7_pkg;

    typedef logic [3:0] char_t;

    localparam char_t CH_A     = 4'd10;
    localparam char_t CH_T     = 4'd11;
    localparam char_t CH_U     = 4'd12;
    localparam char_t CH_DASH  = 4'd13;
    localparam char_t CH_E     = 4'd14;
    localparam char_t CH_BLANK = 4'd15;

    // Active-low patterns, bit order g..a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_T     = 7'h07;
    localparam logic [6:0] SEG_U     = 7'h41;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational character-code to active-low segment decoder.
module seg7_char_decode
    import seg7_pkg::*;
(
    input  char_t       code_i,
    output logic [6:0]  seg_o
);

    // Code lookup; anything unexpected falls back to dark segments
    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'd0:     seg_o = SEG_0;
            4'd1:     seg_o = SEG_1;
            4'd2:     seg_o = SEG_2;
            4'd3:     seg_o = SEG_3;
            4'd4:     seg_o = SEG_4;
            4'd5:     seg_o = SEG_5;
            4'd6:     seg_o = SEG_6;
            4'd7:     seg_o = SEG_7;
            4'd8:     seg_o = SEG_8;
            4'd9:     seg_o = SEG_9;
            CH_A:     seg_o = SEG_A;
            CH_T:     seg_o = SEG_T;
            CH_U:     seg_o = SEG_U;
            CH_DASH:  seg_o = SEG_DASH;
            CH_E:     seg_o = SEG_E;
            CH_BLANK: seg_o = SEG_BLANK;
            default:  seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with a double-buffered frame
// that only commits on scan-frame boundaries.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD        = 4,
    parameter int BLINK_FRAMES = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   chars,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic [NUM_DIGITS-1:0]     blink,
    input  logic                      load,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [7:0]                ca,
    output logic                      frame_tick
);

    localparam int DIV_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int IDX_W = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIV_W-1:0]          div_q, div_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [FRM_W-1:0]          frm_q, frm_d;
    logic                      phase_q, phase_d;
    logic                      pend_valid_q;
    logic [4*NUM_DIGITS-1:0]   pend_chars_q, act_chars_q;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_blank_q, pend_blink_q;
    logic [NUM_DIGITS-1:0]     act_dp_q, act_blank_q, act_blink_q;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic [7:0]                ca_q, ca_d;
    logic                      tick_q;

    logic                      div_wrap_s;
    logic                      frame_end_s;
    char_t                     cur_code_s;
    logic [6:0]                seg_s;
    logic                      dark_s;

    seg7_char_decode u_decode (
        .code_i (cur_code_s),
        .seg_o  (seg_s)
    );

    // Next-state for prescaler, digit index and blink timing
    always_comb begin
        div_wrap_s  = (div_q == DIV_W'(SCAN_DIV - 1));
        frame_end_s = div_wrap_s && (idx_q == IDX_W'(NUM_DIGITS - 1));
        div_d       = div_wrap_s ? '0 : div_q + DIV_W'(1);
        idx_d       = idx_q;
        frm_d       = frm_q;
        phase_d     = phase_q;
        if (frame_end_s) begin
            idx_d = '0;
            if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end else if (div_wrap_s) begin
            idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    // Output pattern; a blank character code is treated as a dark digit
    always_comb begin
        cur_code_s = act_chars_q[{idx_q, 2'b00} +: 4];
        dark_s     = (div_q < DIV_W'(GUARD)) || act_blank_q[idx_q] ||
                     (act_blink_q[idx_q] && phase_q) || (cur_code_s == CH_BLANK);
        an_d       = '1;
        ca_d       = 8'hFF;
        if (!dark_s) begin
            an_d[idx_q] = 1'b0;
            ca_d        = {~act_dp_q[idx_q], seg_s};
        end else begin
            an_d = '1;
            ca_d = 8'hFF;
        end
    end

    // Scan counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            idx_q   <= '0;
            frm_q   <= '0;
            phase_q <= 1'b0;
            an_q    <= '1;
            ca_q    <= 8'hFF;
            tick_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            ca_q    <= ca_d;
            tick_q  <= frame_end_s;
        end
    end

    // Pending/active frame buffers; boundary commit happens before a same-cycle load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_chars_q <= '1;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            pend_blink_q <= '0;
            act_chars_q  <= '1;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            act_blink_q  <= '0;
        end else begin
            if (frame_end_s && pend_valid_q) begin
                act_chars_q  <= pend_chars_q;
                act_dp_q     <= pend_dp_q;
                act_blank_q  <= pend_blank_q;
                act_blink_q  <= pend_blink_q;
                pend_valid_q <= 1'b0;
            end
            if (load) begin
                pend_chars_q <= chars;
                pend_dp_q    <= dp;
                pend_blank_q <= blank;
                pend_blink_q <= blink;
                pend_valid_q <= 1'b1;
            end
        end
    end

    assign an         = an_q;
    assign ca         = ca_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a cycle-count
// based reference model of the scan schedule and frame buffering.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int GD = 2;
    localparam int BF = 2;
    localparam int FRAME = ND * SD;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [15:0]     chars = 16'h0;
    logic [3:0]      dp = 4'h0, blank = 4'h0, blink = 4'h0;
    logic            load = 1'b0;
    logic [3:0]      an;
    logic [7:0]      ca;
    logic            frame_tick;

    int              n_checks = 0;
    int              n_errors = 0;

    // Reference model state: cycles since reset release plus both buffers
    int              k;
    logic [15:0]     a_ch, p_ch;
    logic [3:0]      a_dp, a_bl, a_bk, p_dp, p_bl, p_bk;
    bit              pv;
    logic [7:0]      tab [16];
    int              tick_count;
    logic [7:0]      last_ca_d1;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .chars(chars), .dp(dp), .blank(blank),
        .blink(blink), .load(load), .an(an), .ca(ca), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at k=%0d: got %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; pv = 1'b0;
        a_ch = 16'hFFFF; a_bl = 4'hF; a_dp = 4'h0; a_bk = 4'h0;
        p_ch = 16'hFFFF; p_bl = 4'hF; p_dp = 4'h0; p_bk = 4'h0;
    endtask

    // One clock: predict outputs from the schedule, advance the model, compare
    task automatic tick();
        int d, i, ph;
        logic [3:0] code;
        bit dark;
        logic [3:0] e_an;
        logic [7:0] e_ca;
        logic e_ft;
        d = k % SD;
        i = (k / SD) % ND;
        ph = ((k / FRAME) / BF) % 2;
        code = a_ch[i*4 +: 4];
        dark = (d < GD) || a_bl[i] || (a_bk[i] && ph == 1) || (code == 4'd15);
        e_an = dark ? 4'hF : ~(4'b0001 << i);
        e_ca = dark ? 8'hFF : (a_dp[i] ? (tab[code] & 8'h7F) : tab[code]);
        e_ft = (k % FRAME == FRAME - 1);
        if (e_ft && pv) begin
            a_ch = p_ch; a_dp = p_dp; a_bl = p_bl; a_bk = p_bk; pv = 1'b0;
        end
        if (load) begin
            p_ch = chars; p_dp = dp; p_bl = blank; p_bk = blink; pv = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("an", {28'd0, an}, {28'd0, e_an});
        check_eq("ca", {24'd0, ca}, {24'd0, e_ca});
        check_eq("frame_tick", {31'd0, frame_tick}, {31'd0, e_ft});
        if (frame_tick) tick_count++;
        if (an == 4'b1101) last_ca_d1 = ca;
        k++;
        load = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] c, input logic [3:0] p,
                           input logic [3:0] b, input logic [3:0] bk);
        chars = c; dp = p; blank = b; blink = bk; load = 1'b1;
        tick();
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    initial begin
        tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h87, 8'hC1, 8'hBF, 8'h86, 8'hFF};
        model_reset();
        tick_count = 0;
        last_ca_d1 = 8'h00;

        repeat (3) @(negedge clk);
        check_eq("rst_an", {28'd0, an}, 32'h0000000F);
        check_eq("rst_ca", {24'd0, ca}, 32'h000000FF);
        check_eq("rst_ft", {31'd0, frame_tick}, 32'd0);
        rst = 1'b0;

        run(3 * FRAME);
        check_eq("tick_count", tick_count, 32'd3);

        do_load(16'h4321, 4'b0010, 4'b0000, 4'b0000);
        run(2 * FRAME);
        check_eq("dp_digit1", {24'd0, last_ca_d1}, 32'h00000024);

        foreach (tab[c]) begin
            if (c >= 10) begin
                do_load({4{4'(c)}}, 4'b0000, 4'b0000, 4'b0000);
                run(FRAME);
            end
        end

        do_load(16'h1111, 4'h0, 4'h0, 4'h0);
        run(5);
        do_load(16'h9999, 4'h0, 4'h0, 4'h0);
        run(2 * FRAME);
        while (k % FRAME != FRAME - 1) tick();
        do_load(16'h5555, 4'h0, 4'h0, 4'h0);
        run(3 * FRAME);

        do_load(16'h8888, 4'h0, 4'h0, 4'b0001);
        run(10 * FRAME);

        for (int j = 0; j < 2000; j++) begin
            if ($urandom_range(19, 0) == 0)
                do_load(16'($urandom), 4'($urandom), 4'($urandom_range(3, 0) == 0 ? $urandom : 0),
                        4'($urandom));
            else
                tick();
        end

        do_load(16'h8888, 4'h0, 4'h0, 4'h0);
        run(2 * FRAME);
        for (int j = 0; j < 40 && an == 4'hF; j++) tick();
        check_eq("lit_before_rst", {31'd0, (an != 4'hF)}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_an", {28'd0, an}, 32'h0000000F);
        check_eq("midrst_ca", {24'd0, ca}, 32'h000000FF);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run(3 * FRAME);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
